// File: rtl/out_display_pkg.sv
// rtl/out_display_pkg.sv - shared types and constants for the OUT display controller
//
// Purpose : conversion FSM state type, default widths and the active-low
//           7-segment glyph table (bit order {g,f,e,d,c,b,a}).
// Ports   : none (package).
package out_display_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DIGITS_DEF = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/out_display_seg7_encode.sv
// rtl/out_display_seg7_encode.sv - one BCD digit to active-low 7-segment glyph
//
// Purpose : combinational decode of a single BCD digit; codes above 9 and
//           an asserted blank both produce an unlit digit.
// Ports   : digit [3:0] in  - BCD digit value
//           blank       in  - force the digit dark
//           seg   [6:0] out - active-low segments {g,f,e,d,c,b,a}
module seg7_encode
  import out_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_DIGIT[0];
        4'd1:    seg = SEG_DIGIT[1];
        4'd2:    seg = SEG_DIGIT[2];
        4'd3:    seg = SEG_DIGIT[3];
        4'd4:    seg = SEG_DIGIT[4];
        4'd5:    seg = SEG_DIGIT[5];
        4'd6:    seg = SEG_DIGIT[6];
        4'd7:    seg = SEG_DIGIT[7];
        4'd8:    seg = SEG_DIGIT[8];
        4'd9:    seg = SEG_DIGIT[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/out_display_ctrl.sv
// rtl/out_display_ctrl.sv - OUT register to sign + BCD 7-segment display controller
//
// Purpose : captures each value written to the CPU OUT register, converts
//           it to sign plus BCD magnitude with a sequential double-dabble,
//           and commits the result atomically to the displays.
// Ports   : clk                    in  - system clock
//           rst                    in  - synchronous active-high reset
//           write_out              in  - one-cycle OUT write strobe
//           data_out [DATA_W-1:0]  in  - two's-complement value written
//           busy                   out - conversion in progress
//           done                   out - one-cycle pulse in the commit cycle
//           pend_ovf               out - sticky: pending value overwritten
//           bcd [4*DIGITS-1:0]     out - committed BCD magnitude, digit0 in [3:0]
//           neg                    out - committed sign
//           seg_sign [6:0]         out - sign digit segments
//           seg_dig [7*DIGITS-1:0] out - digit segments, digit i in [7i+6:7i]
module out_display_ctrl
  import out_display_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DIGITS   = DIGITS_DEF,
  parameter int LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_out,
  input  logic [DATA_W-1:0]     data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pend_ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic [6:0]            seg_sign,
  output logic [7*DIGITS-1:0]   seg_dig
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int MAG_W = DATA_W + 1;
  localparam int SR_W  = BCD_W + MAG_W;
  localparam int CNT_W = $clog2(DATA_W + 2);
  // cnt reaches this after the last of the DATA_W+1 shifts; that cycle is a
  // settle cycle with no shift, which fixes the load-to-commit latency.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W + 1);

  state_t              state, state_nxt;
  logic [SR_W-1:0]     sr, sr_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                neg_work, neg_work_nxt;
  logic [DATA_W-1:0]   pend_data, pend_data_nxt;
  logic                pend_valid, pend_valid_nxt;
  logic                pend_ovf_nxt;
  logic                commit;
  logic                load_en;
  logic [DATA_W-1:0]   load_val;

  // Magnitude is one bit wider than the input so the most negative value
  // converts without overflow.
  function automatic logic [SR_W-1:0] load_sr(input logic [DATA_W-1:0] d);
    logic [MAG_W-1:0] ext;
    logic [MAG_W-1:0] mag;
    ext = {d[DATA_W-1], d};
    mag = d[DATA_W-1] ? (~ext + MAG_W'(1)) : ext;
    return {{BCD_W{1'b0}}, mag};
  endfunction

  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (t[MAG_W + 4*k +: 4] >= 4'd5)
        t[MAG_W + 4*k +: 4] = t[MAG_W + 4*k +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  always_comb begin
    state_nxt      = state;
    sr_nxt         = sr;
    cnt_nxt        = cnt;
    neg_work_nxt   = neg_work;
    pend_data_nxt  = pend_data;
    pend_valid_nxt = pend_valid;
    pend_ovf_nxt   = pend_ovf;
    commit         = 1'b0;
    done           = 1'b0;
    load_en        = 1'b0;
    load_val       = data_out;

    case (state)
      IDLE: begin
        if (write_out) begin
          load_en  = 1'b1;
          load_val = data_out;
        end
      end

      SHIFT: begin
        if (cnt == CNT_LAST) begin
          state_nxt = COMMIT;
        end else begin
          sr_nxt  = dabble(sr);
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (write_out) begin
          if (pend_valid) pend_ovf_nxt = 1'b1;
          pend_data_nxt  = data_out;
          pend_valid_nxt = 1'b1;
        end
      end

      COMMIT: begin
        done      = 1'b1;
        commit    = 1'b1;
        state_nxt = IDLE;
        // A write landing in this cycle is the newest value, so it wins
        // over anything already queued and starts right away.
        if (write_out) begin
          if (pend_valid) pend_ovf_nxt = 1'b1;
          load_en        = 1'b1;
          load_val       = data_out;
          pend_valid_nxt = 1'b0;
        end else if (pend_valid) begin
          load_en        = 1'b1;
          load_val       = pend_data;
          pend_valid_nxt = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (load_en) begin
      sr_nxt       = load_sr(load_val);
      neg_work_nxt = load_val[DATA_W-1];
      cnt_nxt      = '0;
      state_nxt    = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      neg_work   <= 1'b0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      pend_ovf   <= 1'b0;
      busy       <= 1'b0;
      bcd        <= '0;
      neg        <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      cnt        <= cnt_nxt;
      neg_work   <= neg_work_nxt;
      pend_data  <= pend_data_nxt;
      pend_valid <= pend_valid_nxt;
      pend_ovf   <= pend_ovf_nxt;
      busy       <= (state_nxt != IDLE);
      if (commit) begin
        bcd <= sr[SR_W-1 -: BCD_W];
        neg <= neg_work;
      end
    end
  end

  assign seg_sign = neg ? SEG_MINUS : SEG_BLANK;

  // blank[i] marks digit i as part of the leading-zero run counted from the
  // MSD; digit0 always shows so zero reads as '0'.
  logic [DIGITS-1:0] blank;
  assign blank[0] = 1'b0;

  for (genvar i = 1; i < DIGITS; i++) begin : g_blank
    if (i == DIGITS - 1) begin : g_top
      assign blank[i] = (LZ_BLANK != 0) && (bcd[4*i +: 4] == 4'd0);
    end else begin : g_mid
      assign blank[i] = blank[i+1] && (bcd[4*i +: 4] == 4'd0);
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    seg7_encode u_seg (
      .digit (bcd[4*i +: 4]),
      .blank (blank[i]),
      .seg   (seg_dig[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_out_display_ctrl.sv
// tb/tb_out_display_ctrl.sv - self-checking bench for out_display_ctrl
module tb_out_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_out;
  logic [15:0] data_out;

  logic        busy, done, pend_ovf, neg;
  logic [19:0] bcd;
  logic [6:0]  seg_sign;
  logic [34:0] seg_dig;

  logic        busy_nb, done_nb, pend_ovf_nb, neg_nb;
  logic [19:0] bcd_nb;
  logic [6:0]  seg_sign_nb;
  logic [34:0] seg_dig_nb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  out_display_ctrl #(.DATA_W(16), .DIGITS(5), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .write_out(write_out), .data_out(data_out),
    .busy(busy), .done(done), .pend_ovf(pend_ovf), .bcd(bcd), .neg(neg),
    .seg_sign(seg_sign), .seg_dig(seg_dig)
  );

  out_display_ctrl #(.DATA_W(16), .DIGITS(5), .LZ_BLANK(0)) dut_nb (
    .clk(clk), .rst(rst), .write_out(write_out), .data_out(data_out),
    .busy(busy_nb), .done(done_nb), .pend_ovf(pend_ovf_nb), .bcd(bcd_nb), .neg(neg_nb),
    .seg_sign(seg_sign_nb), .seg_dig(seg_dig_nb)
  );

  typedef struct {
    logic [15:0] data;
    logic [19:0] bcd;
    logic        neg;
    logic [6:0]  sign;
    logic [34:0] seg;
    logic [34:0] seg_nb;
  } vec_t;

  vec_t vecs [7];

  localparam logic [34:0] IMG_RESET    = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [34:0] IMG_RESET_NB = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [34:0] prev_seg, prev_nb;
    int cyc, busy_cnt, t;
    logic seen, saw8, saw_done;

    vecs[0] = '{16'h3039, 20'h12345, 1'b0, 7'h7F,
                {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
    vecs[1] = '{16'hFFFF, 20'h00001, 1'b1, 7'h3F,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79}, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79}};
    vecs[2] = '{16'h8000, 20'h32768, 1'b1, 7'h3F,
                {7'h30, 7'h24, 7'h78, 7'h02, 7'h00}, {7'h30, 7'h24, 7'h78, 7'h02, 7'h00}};
    vecs[3] = '{16'hFFD6, 20'h00042, 1'b1, 7'h3F,
                {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, {7'h40, 7'h40, 7'h40, 7'h19, 7'h24}};
    vecs[4] = '{16'h0000, 20'h00000, 1'b0, 7'h7F,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{16'h0064, 20'h00100, 1'b0, 7'h7F,
                {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}, {7'h40, 7'h40, 7'h79, 7'h40, 7'h40}};
    vecs[6] = '{16'h7FFF, 20'h32767, 1'b0, 7'h7F,
                {7'h30, 7'h24, 7'h78, 7'h02, 7'h78}, {7'h30, 7'h24, 7'h78, 7'h02, 7'h78}};

    // Reset image
    rst = 1'b1; write_out = 1'b0; data_out = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset pend_ovf", 64'(pend_ovf), 64'd0);
    check("reset bcd", 64'(bcd), 64'd0);
    check("reset neg", 64'(neg), 64'd0);
    check("reset seg_sign", 64'(seg_sign), 64'h7F);
    check("reset seg_dig", 64'(seg_dig), 64'(IMG_RESET));
    check("reset seg_dig nb", 64'(seg_dig_nb), 64'(IMG_RESET_NB));

    // Table-driven single conversions
    prev_seg = IMG_RESET;
    prev_nb  = IMG_RESET_NB;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); write_out = 1'b1; data_out = vecs[i].data;
      @(negedge clk); write_out = 1'b0;
      busy_cnt = busy ? 1 : 0;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 60) begin
        @(negedge clk); cyc++;
        if (busy) busy_cnt++;
        if (done) seen = 1'b1;
      end
      check($sformatf("v%0d done latency", i), 64'(cyc), 64'd18);
      check($sformatf("v%0d busy cycles", i), 64'(busy_cnt), 64'd19);
      check($sformatf("v%0d display held", i), 64'(seg_dig), 64'(prev_seg));
      @(negedge clk);
      check($sformatf("v%0d bcd", i), 64'(bcd), 64'(vecs[i].bcd));
      check($sformatf("v%0d neg", i), 64'(neg), 64'(vecs[i].neg));
      check($sformatf("v%0d seg_sign", i), 64'(seg_sign), 64'(vecs[i].sign));
      check($sformatf("v%0d seg_dig", i), 64'(seg_dig), 64'(vecs[i].seg));
      check($sformatf("v%0d seg_dig nb", i), 64'(seg_dig_nb), 64'(vecs[i].seg_nb));
      check($sformatf("v%0d busy after", i), 64'(busy), 64'd0);
      prev_seg = vecs[i].seg;
      prev_nb  = vecs[i].seg_nb;
    end

    // Pending overwrite: 7 at N, 8 at N+3, 9 at N+5
    saw8 = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c > 0 && bcd == 20'h8) saw8 = 1'b1;
      write_out = 1'b0;
      if (c == 0) begin write_out = 1'b1; data_out = 16'd7; end
      if (c == 3) begin write_out = 1'b1; data_out = 16'd8; end
      if (c == 5) begin write_out = 1'b1; data_out = 16'd9; end
    end
    @(negedge clk); write_out = 1'b0;
    t = 5; seen = 1'b0;
    while (!seen && t < 80) begin
      @(negedge clk); t++;
      if (bcd == 20'h8) saw8 = 1'b1;
      if (done) seen = 1'b1;
    end
    check("pend first done time", 64'(t), 64'd18);
    @(negedge clk); t++;
    check("pend first bcd", 64'(bcd), 64'h7);
    check("pend ovf set", 64'(pend_ovf), 64'd1);
    seen = 1'b0;
    while (!seen && t < 80) begin
      @(negedge clk); t++;
      if (bcd == 20'h8) saw8 = 1'b1;
      if (done) seen = 1'b1;
    end
    check("pend second done time", 64'(t), 64'd37);
    @(negedge clk);
    check("pend second bcd", 64'(bcd), 64'h9);
    check("pend 8 never shown", 64'(saw8), 64'd0);

    // Reset in the middle of a conversion
    @(negedge clk); write_out = 1'b1; data_out = 16'd500;
    @(negedge clk); write_out = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midrst no done", 64'(saw_done), 64'd0);
    check("midrst bcd", 64'(bcd), 64'd0);
    check("midrst seg_dig", 64'(seg_dig), 64'(IMG_RESET));
    check("midrst seg_sign", 64'(seg_sign), 64'h7F);
    check("midrst pend_ovf", 64'(pend_ovf), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
